ring_addr_sequencer: RTL and testbench
======================================

Name: ring_addr_sequencer

Overview:
- Upstream stage of the address encoder in CNN_Two_Layer.
- Generates the 15-bit one-hot ring pattern that selects one of 15 data entries (weights/pixels) per accepted beat.
- Runs a programmable number of full passes per Start, with a valid/ready handshake toward the consumer and a Done pulse at the end.
- Output ordering must give encoded addresses 0,1,2,…,14 per pass:
  - first pattern is bit 14 (encodes to 0);
  - then bit 0 through bit 13 (encode to 1..14).

Parameters:
- DATANUM, 15: ring width = entries per pass. Fixed at 15 for the encoder pairing; all rules below assume it.
- PASSES, 1: full passes per Start, legal range 1..2^PASS_W-1.
- PASS_W, 4: width of the pass counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin a sequence. Sampled only in IDLE.
- Abort  in  1  synchronous cancel, valid in any state.
- Ready  in  1  consumer accepts the current RingOut this cycle.
- RingOut  out  DATANUM  one-hot ring pattern, to be fed to the address encoder.
- Valid  out  1  RingOut is a live beat.
- Last  out  1  current beat is the final beat of the final pass.
- PassCnt  out  PASS_W  index of the current pass, 0-based.
- Busy  out  1  high in RUN and DONE.
- Done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - RingOut = 15'h4000 (bit 14 only).
  - State = IDLE.
  - Valid = 0, Last = 0, Busy = 0, Done = 0, PassCnt = 0.
- All outputs are registered. No combinational path from any input to any output.
- Handshake: a beat is accepted when Valid=1 and Ready=1 in the same cycle.
- Rotation: RingOut_next = {RingOut[13:0], RingOut[14]}. Rotation happens only on an accepted beat. Ready=0 holds RingOut and all flags.
- IDLE:
  - RingOut is held at 15'h4000; Valid = 0.
  - Start=1 (with Abort=0) moves to RUN on the next edge.
  - First RUN cycle: Valid=1, RingOut=15'h4000, PassCnt=0.
  - Start-to-Valid latency is 1 cycle.
- RUN:
  - Valid=1 throughout.
  - Last=1 exactly when RingOut[13]=1 and PassCnt=PASSES-1.
  - Accepted beat at bit 13, not last pass: ring wraps to bit 14, PassCnt increments, stay in RUN.
  - Accepted beat with Last=1: ring returns to 15'h4000, go to DONE, Valid=0, Last=0.
- DONE:
  - Lasts exactly one cycle: Done=1, Busy=1, Valid=0.
  - Then returns to IDLE with PassCnt=0.
  - Start during DONE is ignored.
- Beat count: exactly DATANUM*PASSES accepted beats per Start (15 for PASSES=1, 45 for PASSES=3).
- Start while in RUN or DONE: ignored, no restart, no queueing.
- Abort (any state, takes effect on the next edge):
  - Go to IDLE, RingOut=15'h4000, PassCnt=0, Valid=0, Last=0.
  - Done is NOT pulsed.
  - Abort and Start together in IDLE: Abort wins, stay in IDLE.
  - Abort coincident with a Ready beat: the beat is dropped, Abort wins.
- Reset mid-operation: outputs go immediately to their reset values, asynchronously, without waiting for clk.
- RingOut stays strictly one-hot in every state under legal operation.

Optional Feature:
- Macro: RING_ONEHOT_CHECK_EN.
- When defined:
  - Add output RingErr (1 bit, reset 0).
  - Each cycle, check RingOut with a popcount; if it is not exactly one, RingErr pulses 1 for one cycle on the next edge.
  - The sequencer self-recovers: RingOut=15'h4000, state IDLE, PassCnt=0, no Done pulse.
- When undefined: no RingErr port, no check logic. Behaviour is otherwise identical.

Test Plan:
- Reset then idle 5 cycles → RingOut=15'h4000, Valid=0, Busy=0, Done=0.
- PASSES=1, Start pulse, Ready held 1 → Valid rises 1 cycle after Start. 15 beats: 15'h4000, 15'h0001, 15'h0002, … 15'h2000. Last only on the 15'h2000 beat. Done pulses once on the following cycle.
- PASSES=3, Ready held 1 → 45 beats. PassCnt steps 0→1→2 on the wrap from 15'h2000 to 15'h4000. Last only at beat 45.
- Ready toggled 1,0,0,1… → RingOut holds during Ready=0. Encoded address sequence stays 0..14 with no skips or repeats.
- Abort asserted on beat 7 with Ready=1 → next cycle: IDLE, RingOut=15'h4000, Valid=0, PassCnt=0, no Done. Start in the same cycle as Abort is ignored.
- With RING_ONEHOT_CHECK_EN: force RingOut to 15'h0003 mid-RUN → RingErr=1 for one cycle, then RingOut=15'h4000, IDLE, no Done.

Source files
------------

// File: rtl/ring_addr_sequencer.sv
// ring_addr_sequencer: one-hot ring generator feeding the CNN address encoder.
// Emits DATANUM one-hot beats per pass (bit 14 first, then bit 0..13 so the
// encoder sees 0..14), for PASSES passes per Start, over a Valid/Ready
// handshake, then pulses Done. All outputs are registered.
// Optional build macro RING_ONEHOT_CHECK_EN adds a RingErr output and a
// popcount watchdog that returns the sequencer to IDLE on a corrupted ring.
module ring_addr_sequencer #(
    parameter int DATANUM = 15,
    parameter int PASSES  = 1,
    parameter int PASS_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Start,
    input  logic               Abort,
    input  logic               Ready,
    output logic [DATANUM-1:0] RingOut,
    output logic               Valid,
    output logic               Last,
    output logic [PASS_W-1:0]  PassCnt,
    output logic               Busy,
`ifdef RING_ONEHOT_CHECK_EN
    output logic               RingErr,
`endif
    output logic               Done
);

    localparam logic [DATANUM-1:0] RING_HOME = {1'b1, {(DATANUM-1){1'b0}}};
    localparam logic [PASS_W-1:0]  LAST_PASS = PASS_W'(PASSES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t               r_state, w_state_nxt;
    logic [DATANUM-1:0]   r_ring,  w_ring_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_last,  w_last_nxt;
    logic [PASS_W-1:0]    r_pass,  w_pass_nxt;
    logic                 r_busy,  w_busy_nxt;
    logic                 r_done,  w_done_nxt;
    logic                 w_accept;
    logic                 w_err;
    logic [DATANUM-1:0]   w_ring_rot;

    assign w_accept   = r_valid & Ready;
    assign w_ring_rot = {r_ring[DATANUM-2:0], r_ring[DATANUM-1]};

`ifdef RING_ONEHOT_CHECK_EN
    logic r_err;

    // Ring must be exactly one-hot; anything else is treated as corruption.
    assign w_err = ($countones(r_ring) != 1);

    // One-cycle error pulse, registered like every other output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_err;
    end

    assign RingErr = r_err;
`else
    assign w_err = 1'b0;
`endif

    // State and registered-output bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ring  <= RING_HOME;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_pass  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ring  <= w_ring_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_pass  <= w_pass_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; Abort / ring corruption override all.
    always_comb begin
        w_state_nxt = r_state;
        w_ring_nxt  = r_ring;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_pass_nxt  = r_pass;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (Abort || w_err) begin
            w_state_nxt = IDLE;
            w_ring_nxt  = RING_HOME;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_pass_nxt  = '0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_ring_nxt  = RING_HOME;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_pass_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                    if (Start) begin
                        w_state_nxt = RUN;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (r_last) begin
                            w_state_nxt = DONE;
                            w_ring_nxt  = RING_HOME;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_ring_nxt = w_ring_rot;
                            if (r_ring[DATANUM-2])
                                w_pass_nxt = r_pass + PASS_W'(1);
                            // Last is looked ahead one beat so it stays registered.
                            w_last_nxt = r_ring[DATANUM-3] && (r_pass == LAST_PASS);
                        end
                    end
                end
                DONE: begin
                    w_state_nxt = IDLE;
                    w_ring_nxt  = RING_HOME;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_pass_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_ring_nxt  = RING_HOME;
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    w_pass_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign RingOut = r_ring;
    assign Valid   = r_valid;
    assign Last    = r_last;
    assign PassCnt = r_pass;
    assign Busy    = r_busy;
    assign Done    = r_done;

endmodule

// File: tb/tb_ring_addr_sequencer.sv
// Bench for ring_addr_sequencer: two instances (PASSES=1 and PASSES=3) share
// stimulus; each is compared every cycle against a beat-index reference model.
module tb_ring_addr_sequencer;

    localparam int DN = 15;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Start = 1'b0, Abort = 1'b0, Ready = 1'b0;

    logic [DN-1:0] ring [2];
    logic          vld [2], lst [2], bsy [2], dne [2];
    logic [PW-1:0] pcnt [2];
`ifdef RING_ONEHOT_CHECK_EN
    logic          rerr [2];
`endif

    int n_chk = 0;
    int n_fail = 0;

    // model: phase 0=IDLE 1=RUN 2=DONE, k = beat index within the Start
    int phase [2];
    int k [2];
    int npass [2];

    always #5 clk = ~clk;

    ring_addr_sequencer #(.DATANUM(DN), .PASSES(1), .PASS_W(PW)) dut1 (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort), .Ready(Ready),
        .RingOut(ring[0]), .Valid(vld[0]), .Last(lst[0]), .PassCnt(pcnt[0]),
        .Busy(bsy[0]),
`ifdef RING_ONEHOT_CHECK_EN
        .RingErr(rerr[0]),
`endif
        .Done(dne[0]));

    ring_addr_sequencer #(.DATANUM(DN), .PASSES(3), .PASS_W(PW)) dut3 (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort), .Ready(Ready),
        .RingOut(ring[1]), .Valid(vld[1]), .Last(lst[1]), .PassCnt(pcnt[1]),
        .Busy(bsy[1]),
`ifdef RING_ONEHOT_CHECK_EN
        .RingErr(rerr[1]),
`endif
        .Done(dne[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // beat k of a pass encodes to address k%15: address 0 is bit 14, address a>0 is bit a-1
    function automatic logic [DN-1:0] pat(input int beat);
        int a;
        logic [DN-1:0] p;
        a = beat % DN;
        p = '0;
        p[(a + DN - 1) % DN] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin phase[i] = 0; k[i] = 0; end
    endtask

    task automatic model_step(input logic s, input logic a, input logic r);
        for (int i = 0; i < 2; i++) begin
            if (a) begin
                phase[i] = 0; k[i] = 0;
            end else if (phase[i] == 0) begin
                if (s) begin phase[i] = 1; k[i] = 0; end
            end else if (phase[i] == 1) begin
                if (r) begin
                    if (k[i] == DN * npass[i] - 1) phase[i] = 2;
                    else k[i]++;
                end
            end else begin
                phase[i] = 0; k[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [DN-1:0] er;
        for (int i = 0; i < 2; i++) begin
            er = (phase[i] == 1) ? pat(k[i]) : {1'b1, {(DN-1){1'b0}}};
            chk($sformatf("ring%0d", i), 32'(ring[i]), 32'(er));
            chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(phase[i] == 1));
            chk($sformatf("last%0d", i), 32'(lst[i]), 32'(phase[i] == 1 && k[i] == DN * npass[i] - 1));
            chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(phase[i] != 0));
            chk($sformatf("done%0d", i), 32'(dne[i]), 32'(phase[i] == 2));
            if (phase[i] != 2)
                chk($sformatf("pass%0d", i), 32'(pcnt[i]), (phase[i] == 1) ? 32'(k[i] / DN) : 32'd0);
`ifdef RING_ONEHOT_CHECK_EN
            chk($sformatf("rerr%0d", i), 32'(rerr[i]), 32'd0);
`endif
        end
    endtask

    task automatic step(input logic s, input logic a, input logic r);
        Start = s; Abort = a; Ready = r;
        @(posedge clk);
        model_step(s, a, r);
        #1;
        check_all();
    endtask

    initial begin
        npass[0] = 1; npass[1] = 3;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // idle 5 cycles
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0);

        // full run, Ready held high; long enough for PASSES=3
        step(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 50; c++) step(1'b0, 1'b0, 1'b1);

        // Ready pattern 1,0,0 repeating
        step(1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 150; c++) step((c % 7) == 0, 1'b0, (c % 3) == 0);

        // Abort on the 7th beat together with Start
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("abort_idle", 32'(vld[1]), 32'd0);
        step(1'b0, 1'b0, 1'b1);

        // asynchronous reset mid-run
        step(1'b1, 1'b0, 1'b1);
        for (int c = 0; c < 9; c++) step(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic
        for (int c = 0; c < 600; c++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);

`ifdef RING_ONEHOT_CHECK_EN
        // corrupt the ring mid-run: error pulse, then recovery to IDLE without Done
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        force dut3.r_ring = 15'h0003;
        @(negedge clk);
        release dut3.r_ring;
        Ready = 1'b0;
        @(posedge clk);
        #1;
        chk("ringerr_pulse", 32'(rerr[1]), 32'd1);
        chk("ringerr_ring", 32'(ring[1]), 32'h4000);
        chk("ringerr_valid", 32'(vld[1]), 32'd0);
        chk("ringerr_done", 32'(dne[1]), 32'd0);
        @(posedge clk);
        #1;
        chk("ringerr_clear", 32'(rerr[1]), 32'd0);
        chk("ringerr_idle", 32'(bsy[1]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
